// File: rtl/seq_multiplier_16_pkg.sv
// Shared constants and FSM encoding for the 16x16 shift-and-add multiplier.
package seq_multiplier_16_pkg;

  localparam int WIDTH_P = 16;
  localparam int STEPS   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_adder_16.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups plus a group-level lookahead unit.
module cla_adder_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  // Carries c1..c3 of a 4-bit block from generate/propagate of its lower three bits.
  function automatic logic [2:0] carries3(input logic [2:0] g, input logic [2:0] p,
                                          input logic c0);
    logic [2:0] c;
    c[0] = g[0] | (p[0] & c0);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  function automatic logic group_g(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [3:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar j = 0; j < 4; j++) begin : g_group
    assign gg[j] = group_g(g[4*j +: 4], p[4*j +: 4]);
    assign gp[j] = &p[4*j +: 4];
    assign c[4*j]         = gc[j];
    assign c[4*j+1 +: 3]  = carries3(g[4*j +: 3], p[4*j +: 3], gc[j]);
  end

  assign gc[0]   = cin;
  assign gc[3:1] = carries3(gg[2:0], gp[2:0], cin);
  assign cout    = group_g(gg, gp) | (&gp & cin);
  assign sum     = p ^ c;

endmodule

// File: rtl/seq_multiplier_16.sv
// Sequential 16x16 unsigned multiplier: one CLA add and one right shift per cycle, 16 steps.
module seq_multiplier_16
  import seq_multiplier_16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output state_t             dbg_state
);

  if (WIDTH != WIDTH_P) begin : g_width_check
    $error("seq_multiplier_16: only WIDTH=16 is supported");
  end

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [4:0]         cnt;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [2*WIDTH-1:0] shifted;

  assign addend    = acc_lo[0] ? mcand : '0;
  // The carry-out lands in acc_hi[15], so no step can lose a bit.
  assign shifted   = {cout, sum, acc_lo[WIDTH-1:1]};
  assign dbg_state = state;

  cla_adder_16 u_adder (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          {acc_hi, acc_lo} <= shifted;
          cnt              <= cnt + 5'd1;
          if (cnt == 5'(STEPS - 1)) begin
            product <= shifted;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier_16.sv
// Directed and random self-checking bench for seq_multiplier_16.
module tb_seq_multiplier_16;
  import seq_multiplier_16_pkg::*;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  state_t      dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  seq_multiplier_16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .dbg_state (dbg_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [15:0] av, input logic [15:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < limit && !ok) begin
      tick();
      n++;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    a     = 16'h0005;
    b     = 16'h0005;
    tick();
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++;
    if (product !== 32'h0) begin bad++; $display("FAIL reset_product: got %h want 0", product); end
    total++;
    if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    reset = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_basic();
    int early;
    early = 0;
    drive_start(16'd3, 16'd5);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_edge0: got %b want 1", busy); end
    total++;
    if (dbg_state !== CALC) begin bad++; $display("FAIL basic_state_edge0: got %0d want 1", dbg_state); end
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (done === 1'b1) early++;
    end
    total++;
    if (early !== 0) begin bad++; $display("FAIL basic_early_done: got %0d pulses want 0", early); end
    tick();
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL basic_done_edge16: got %b want 1", done); end
    total++;
    if (product !== 32'h0000000F) begin bad++; $display("FAIL basic_product: got %h want 0000000f", product); end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_edge17: got done=%b busy=%b want 0 0", done, busy);
    end
    total++;
    if (product !== 32'h0000000F) begin bad++; $display("FAIL basic_product_hold: got %h want 0000000f", product); end
  endtask

  task automatic test_max();
    int n; bit ok;
    drive_start(16'hFFFF, 16'hFFFF);
    wait_done(30, n, ok);
    total++;
    if (!ok || n != 16) begin bad++; $display("FAIL max_latency: got ok=%0d n=%0d want 1 16", ok, n); end
    total++;
    if (product !== 32'hFFFE0001) begin bad++; $display("FAIL max_product: got %h want fffe0001", product); end
    tick();
  endtask

  task automatic test_zero_identity();
    int n; bit ok;
    drive_start(16'h1234, 16'h0000);
    wait_done(30, n, ok);
    total++;
    if (!ok || n != 16) begin bad++; $display("FAIL zero_latency: got ok=%0d n=%0d want 1 16", ok, n); end
    total++;
    if (product !== 32'h0) begin bad++; $display("FAIL zero_product: got %h want 00000000", product); end
    tick();
    drive_start(16'h8000, 16'h0002);
    wait_done(30, n, ok);
    total++;
    if (!ok || n != 16) begin bad++; $display("FAIL ident_latency: got ok=%0d n=%0d want 1 16", ok, n); end
    total++;
    if (product !== 32'h00010000) begin bad++; $display("FAIL ident_product: got %h want 00010000", product); end
    tick();
  endtask

  task automatic test_ignored_start();
    int pulses, first_at;
    logic [31:0] seen;
    pulses   = 0;
    first_at = -1;
    seen     = '0;
    drive_start(16'h00AB, 16'h0010);
    for (int k = 1; k <= 4; k++) tick();
    a     = 16'd7;
    b     = 16'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    for (int j = 1; j <= 30; j++) begin
      tick();
      if (done === 1'b1) begin
        pulses++;
        if (first_at < 0) begin first_at = j; seen = product; end
      end
    end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL ign_pulses: got %0d want 1", pulses); end
    total++;
    if (first_at != 11) begin bad++; $display("FAIL ign_done_edge: got %0d want 11", first_at); end
    total++;
    if (seen !== 32'h00000AB0) begin bad++; $display("FAIL ign_product: got %h want 00000ab0", seen); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL ign_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int n; bit ok;
    drive_start(16'h0100, 16'h0100);
    for (int k = 1; k <= 7; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL mid_reset_flags: got busy=%b done=%b want 0 0", busy, done);
    end
    total++;
    if (product !== 32'h0) begin bad++; $display("FAIL mid_reset_product: got %h want 00000000", product); end
    total++;
    if (dbg_state !== IDLE) begin bad++; $display("FAIL mid_reset_state: got %0d want 0", dbg_state); end
    tick();
    drive_start(16'd2, 16'd9);
    wait_done(30, n, ok);
    total++;
    if (!ok || n != 16) begin bad++; $display("FAIL mid_restart_latency: got ok=%0d n=%0d want 1 16", ok, n); end
    total++;
    if (product !== 32'h00000012) begin bad++; $display("FAIL mid_restart_product: got %h want 00000012", product); end
    tick();
  endtask

  task automatic test_back_to_back();
    localparam int NDIR = 5;
    localparam int NOPS = NDIR + 1000;
    logic [15:0] av[NOPS];
    logic [15:0] bv[NOPS];
    logic [31:0] ev[NOPS];
    logic [31:0] exp_p;
    int n, want_n;
    bit ok;
    av[0] = 16'd3;    bv[0] = 16'd5;    ev[0] = 32'h0000000F;
    av[1] = 16'hFFFF; bv[1] = 16'hFFFF; ev[1] = 32'hFFFE0001;
    av[2] = 16'h1234; bv[2] = 16'h0000; ev[2] = 32'h00000000;
    av[3] = 16'h8000; bv[3] = 16'h0002; ev[3] = 32'h00010000;
    av[4] = 16'd2;    bv[4] = 16'd9;    ev[4] = 32'h00000012;
    for (int i = NDIR; i < NOPS; i++) begin
      av[i] = 16'($urandom_range(0, 65535));
      bv[i] = 16'($urandom_range(0, 65535));
      ev[i] = {16'h0, av[i]} * {16'h0, bv[i]};
    end
    a     = av[0];
    b     = bv[0];
    exp_q.push_back(ev[0]);
    start = 1'b1;
    for (int i = 0; i < NOPS; i++) begin
      wait_done(40, n, ok);
      want_n = (i == 0) ? 17 : 18;
      total++;
      if (!ok || n != want_n) begin
        bad++; $display("FAIL b2b_interval op%0d: got ok=%0d n=%0d want 1 %0d", i, ok, n, want_n);
      end
      exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
      total++;
      if (product !== exp_p) begin
        bad++; $display("FAIL b2b_product op%0d a=%h b=%h: got %h want %h", i, av[i], bv[i], product, exp_p);
      end
      if (i + 1 < NOPS) begin
        a = av[i+1];
        b = bv[i+1];
        exp_q.push_back(ev[i+1]);
      end else begin
        start = 1'b0;
      end
    end
    tick();
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_final_idle: got busy=%b want 0", busy); end
  endtask

  // sequence and final report
  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    test_reset();
    test_basic();
    test_max();
    test_zero_identity();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
